video_dram_sched: RTL and testbench

- Per-DRAM-cycle slot scheduler that shares the single DRAM port between the video fetcher and two other requesters, CPU and DMA.
- Uses the video bandwidth descriptor (total window size plus video slots needed) that the video mode decoder produces.
- Reserves video slots at the head of each window and hands every other slot to CPU/DMA.
- Sits between the video mode decoder/fetcher and the DRAM controller. It returns read-data strobes to whichever requester owned each slot.

---
 rtl/video_dram_sched_pkg.sv | 50 +++++
 rtl/video_dram_sched_if.sv | 44 ++++
 rtl/video_dram_sched_ret_pipe.sv | 47 ++++
 rtl/video_dram_sched.sv | 132 +++++++++++++
 tb/tb_video_dram_sched.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_dram_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Bandwidth-descriptor encodings, owner tags and decode helpers
//               shared by the video mode decoder and the DRAM slot scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam logic [1:0] BW2 = 2'b00;
    localparam logic [1:0] BW4 = 2'b01;
    localparam logic [1:0] BW8 = 2'b11;

    localparam logic [2:0] BU1 = 3'b001;
    localparam logic [2:0] BU2 = 3'b010;
    localparam logic [2:0] BU4 = 3'b100;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_t;

    // Code 10 is not a legal window size and is treated as the largest one.
    function automatic logic [3:0] bw_size(input logic [1:0] ws);
        logic [3:0] sz;
        case (ws)
            BW2:     sz = 4'd2;
            BW4:     sz = 4'd4;
            default: sz = 4'd8;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] bw_need(input logic [4:0] bw);
        logic [3:0] n;
        logic [3:0] sz;
        sz = bw_size(bw[4:3]);
        case (bw[2:0])
            BU1:     n = 4'd1;
            BU2:     n = 4'd2;
            BU4:     n = 4'd4;
            default: n = 4'd0;
        endcase
        return (n > sz) ? sz : n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_dram_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : video_dram_sched_if
// Description : Requester and DRAM-port bundle around the slot scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_dram_sched_if #(
    parameter int AW = 21
);
    logic          dram_stb;
    logic [4:0]    video_bw;
    logic          vid_go;
    logic [AW-1:0] video_addr;
    logic          cpu_req;
    logic          cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic          dma_req;
    logic          dma_rnw;
    logic [AW-1:0] dma_addr;
    logic          dram_req;
    logic          dram_rnw;
    logic [AW-1:0] dram_addr;
    logic          gnt_vid;
    logic          gnt_cpu;
    logic          gnt_dma;
    logic          vid_strb;
    logic          cpu_strb;
    logic          dma_strb;

    modport master (
        output dram_stb, video_bw, vid_go, video_addr,
        output cpu_req, cpu_rnw, cpu_addr, dma_req, dma_rnw, dma_addr,
        input  dram_req, dram_rnw, dram_addr, gnt_vid, gnt_cpu, gnt_dma,
        input  vid_strb, cpu_strb, dma_strb
    );

    modport slave (
        input  dram_stb, video_bw, vid_go, video_addr,
        input  cpu_req, cpu_rnw, cpu_addr, dma_req, dma_rnw, dma_addr,
        output dram_req, dram_rnw, dram_addr, gnt_vid, gnt_cpu, gnt_dma,
        output vid_strb, cpu_strb, dma_strb
    );
endinterface
`default_nettype wire

// File: rtl/video_dram_sched_ret_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dram_ret_pipe
// Description : Slot-owner tag delay line; strobes the owner of returning data.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_ret_pipe
    import video_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  wire    clk,
    input  wire    rst_n,
    input  wire    dram_stb,
    input  owner_t push_tag,
    output logic   vid_strb,
    output logic   cpu_strb,
    output logic   dma_strb
);

    owner_t r_tags [RD_LAT];
    owner_t w_out;

    assign w_out = r_tags[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) r_tags[i] <= OWN_NONE;
            vid_strb <= 1'b0;
            cpu_strb <= 1'b0;
            dma_strb <= 1'b0;
        end else begin
            vid_strb <= 1'b0;
            cpu_strb <= 1'b0;
            dma_strb <= 1'b0;
            if (dram_stb) begin
                vid_strb  <= (w_out == OWN_VID);
                cpu_strb  <= (w_out == OWN_CPU);
                dma_strb  <= (w_out == OWN_DMA);
                r_tags[0] <= push_tag;
                for (int i = 1; i < RD_LAT; i++) r_tags[i] <= r_tags[i-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_dram_sched.sv
`default_nettype none
// ============================================================================
// Module      : video_dram_sched
// Description : Per-slot DRAM arbiter: video slots at window head, CPU/DMA
//               round-robin elsewhere, read strobes routed back to owners.
// Revision    : 1.0 - initial release
// ============================================================================
module video_dram_sched
    import video_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = 21
) (
    input  wire              clk,
    input  wire              rst_n,
    video_dram_sched_if.slave bus
);

    logic [2:0]    r_cnt;
    logic [4:0]    r_bw;
    logic          r_go;
    logic          r_ptr_dma;
    logic          r_req;
    logic          r_rnw;
    logic [AW-1:0] r_addr;
    logic          r_gnt_vid;
    logic          r_gnt_cpu;
    logic          r_gnt_dma;

    logic          w_win_start;
    logic [4:0]    w_bw;
    logic          w_go;
    logic [3:0]    w_size;
    logic [3:0]    w_need;
    logic          w_last;
    owner_t        w_owner;
    logic          w_rnw;
    logic [AW-1:0] w_addr;
    owner_t        w_push;

    // Slot 0 decides with the descriptor being latched, not the stale one.
    always_comb begin
        w_win_start = (r_cnt == 3'd0);
        w_bw        = w_win_start ? bus.video_bw : r_bw;
        w_go        = w_win_start ? bus.vid_go   : r_go;
        w_size      = bw_size(w_bw[4:3]);
        w_need      = bw_need(w_bw);
        w_last      = ({1'b0, r_cnt} == (w_size - 4'd1));
        w_owner     = OWN_NONE;
        w_rnw       = 1'b0;
        w_addr      = '0;
        if (w_go && ({1'b0, r_cnt} < w_need))
            w_owner = OWN_VID;
        else if (bus.cpu_req && bus.dma_req)
            w_owner = r_ptr_dma ? OWN_DMA : OWN_CPU;
        else if (bus.cpu_req)
            w_owner = OWN_CPU;
        else if (bus.dma_req)
            w_owner = OWN_DMA;
        case (w_owner)
            OWN_VID: begin w_rnw = 1'b1;        w_addr = bus.video_addr; end
            OWN_CPU: begin w_rnw = bus.cpu_rnw; w_addr = bus.cpu_addr;   end
            OWN_DMA: begin w_rnw = bus.dma_rnw; w_addr = bus.dma_addr;   end
            default: begin w_rnw = 1'b0;        w_addr = '0;             end
        endcase
        w_push = w_rnw ? w_owner : OWN_NONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= 3'd0;
            r_bw      <= {BW8, BU1};
            r_go      <= 1'b0;
            r_ptr_dma <= 1'b0;
            r_req     <= 1'b0;
            r_rnw     <= 1'b0;
            r_addr    <= '0;
            r_gnt_vid <= 1'b0;
            r_gnt_cpu <= 1'b0;
            r_gnt_dma <= 1'b0;
        end else begin
            r_gnt_vid <= 1'b0;
            r_gnt_cpu <= 1'b0;
            r_gnt_dma <= 1'b0;
            if (bus.dram_stb) begin
                r_cnt <= w_last ? 3'd0 : r_cnt + 3'd1;
                if (w_win_start) begin
                    r_bw <= bus.video_bw;
                    r_go <= bus.vid_go;
                end
                // Whoever wins a free slot hands priority to the other requester.
                if (w_owner == OWN_CPU) r_ptr_dma <= 1'b1;
                if (w_owner == OWN_DMA) r_ptr_dma <= 1'b0;
                r_req     <= (w_owner != OWN_NONE);
                r_rnw     <= w_rnw;
                r_addr    <= w_addr;
                r_gnt_vid <= (w_owner == OWN_VID);
                r_gnt_cpu <= (w_owner == OWN_CPU);
                r_gnt_dma <= (w_owner == OWN_DMA);
            end
        end
    end

    assign bus.dram_req  = r_req;
    assign bus.dram_rnw  = r_rnw;
    assign bus.dram_addr = r_addr;
    assign bus.gnt_vid   = r_gnt_vid;
    assign bus.gnt_cpu   = r_gnt_cpu;
    assign bus.gnt_dma   = r_gnt_dma;

    logic w_vid_strb;
    logic w_cpu_strb;
    logic w_dma_strb;

    dram_ret_pipe #(
        .RD_LAT (RD_LAT)
    ) u_ret_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .dram_stb (bus.dram_stb),
        .push_tag (w_push),
        .vid_strb (w_vid_strb),
        .cpu_strb (w_cpu_strb),
        .dma_strb (w_dma_strb)
    );

    assign bus.vid_strb = w_vid_strb;
    assign bus.cpu_strb = w_cpu_strb;
    assign bus.dma_strb = w_dma_strb;

endmodule
`default_nettype wire

// File: tb/tb_video_dram_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_dram_sched
// Description : Directed slot-by-slot vectors for the DRAM slot scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_dram_sched;
    import video_pkg::*;

    localparam int            AW = 21;
    localparam logic [AW-1:0] VA = 21'h00100;
    localparam logic [AW-1:0] CA = 21'h00200;
    localparam logic [AW-1:0] DA = 21'h00300;

    // Owner codes used in the table: 0 none, 1 video, 2 CPU, 3 DMA
    localparam logic [1:0] N = 2'd0;
    localparam logic [1:0] V = 2'd1;
    localparam logic [1:0] C = 2'd2;
    localparam logic [1:0] D = 2'd3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_dram_sched_if #(.AW(AW)) bus ();

    video_dram_sched #(
        .RD_LAT (2),
        .AW     (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       cr;
        logic       cw;
        logic       dr;
        logic       dw;
        logic       go;
        logic [4:0] bw;
        logic [1:0] g;
        logic [1:0] s;
    } vec_t;

    vec_t tbl[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] o);
        case (o)
            2'd1:    return 3'b100;
            2'd2:    return 3'b010;
            2'd3:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] exp_bus(input vec_t v);
        logic          rnw;
        logic [AW-1:0] addr;
        case (v.g)
            2'd1:    begin rnw = 1'b1; addr = VA; end
            2'd2:    begin rnw = v.cw; addr = CA; end
            2'd3:    begin rnw = v.dw; addr = DA; end
            default: begin rnw = 1'b0; addr = '0; end
        endcase
        return {9'd0, (v.g != 2'd0), rnw, addr};
    endfunction

    function automatic logic [31:0] all_out();
        return {3'd0, bus.dram_req, bus.dram_rnw, bus.dram_addr,
                bus.gnt_vid, bus.gnt_cpu, bus.gnt_dma,
                bus.vid_strb, bus.cpu_strb, bus.dma_strb};
    endfunction

    function automatic logic [31:0] gnt_now();
        return {29'd0, bus.gnt_vid, bus.gnt_cpu, bus.gnt_dma};
    endfunction

    function automatic logic [31:0] strb_now();
        return {29'd0, bus.vid_strb, bus.cpu_strb, bus.dma_strb};
    endfunction

    function automatic logic [31:0] bus_now();
        return {9'd0, bus.dram_req, bus.dram_rnw, bus.dram_addr};
    endfunction

    task automatic add(input logic cr, input logic cw, input logic dr, input logic dw,
                       input logic go, input logic [4:0] bw,
                       input logic [1:0] g, input logic [1:0] s);
        vec_t v;
        v.cr = cr; v.cw = cw; v.dr = dr; v.dw = dw;
        v.go = go; v.bw = bw; v.g = g; v.s = s;
        tbl.push_back(v);
    endtask

    // One DRAM slot: strobe for one clk, sample #1 after that edge.
    task automatic drive_slot(input vec_t v);
        @(negedge clk);
        bus.cpu_req  = v.cr;
        bus.cpu_rnw  = v.cw;
        bus.dma_req  = v.dr;
        bus.dma_rnw  = v.dw;
        bus.vid_go   = v.go;
        bus.video_bw = v.bw;
        bus.dram_stb = 1'b1;
        @(posedge clk);
        #1;
        bus.dram_stb = 1'b0;
    endtask

    initial begin
        vec_t v;

        bus.dram_stb   = 1'b0;
        bus.video_bw   = 5'b11_001;
        bus.vid_go     = 1'b0;
        bus.video_addr = VA;
        bus.cpu_req    = 1'b0;
        bus.cpu_rnw    = 1'b1;
        bus.cpu_addr   = CA;
        bus.dma_req    = 1'b0;
        bus.dma_rnw    = 1'b1;
        bus.dma_addr   = DA;

        // 8-slot window, 1 video slot, CPU fills; last slot DMA-only
        add(1,1,0,1,1,5'b11_001, V, N);
        add(1,1,0,1,1,5'b11_001, C, N);
        add(1,1,0,1,1,5'b11_001, C, V);
        add(1,1,0,1,1,5'b11_001, C, C);
        add(1,1,0,1,1,5'b11_001, C, C);
        add(1,1,0,1,1,5'b11_001, C, C);
        add(1,1,0,1,1,5'b11_001, C, C);
        add(0,1,1,1,1,5'b11_001, D, C);
        // 4-slot window, CPU and DMA both requesting
        add(1,1,1,1,1,5'b01_001, V, C);
        add(1,1,1,1,1,5'b01_001, C, D);
        add(1,1,1,1,1,5'b01_001, D, V);
        add(1,1,1,1,1,5'b01_001, C, C);
        add(1,1,1,1,1,5'b01_001, V, D);
        add(1,1,1,1,1,5'b01_001, D, C);
        add(1,1,1,1,1,5'b01_001, C, V);
        add(1,1,1,1,1,5'b01_001, D, D);
        // 2-slot window needing 4: clamped to 2 video slots
        add(1,1,0,1,1,5'b00_100, V, C);
        add(1,1,0,1,1,5'b00_100, V, D);
        add(1,1,0,1,1,5'b00_100, V, V);
        add(1,1,0,1,1,5'b00_100, V, V);
        // Video off: CPU takes everything
        add(1,1,0,1,0,5'b00_100, C, V);
        add(1,1,0,1,0,5'b00_100, C, V);
        // CPU write returns nothing, CPU read returns after two slots
        add(1,0,0,1,0,5'b00_100, C, C);
        add(1,1,0,1,0,5'b00_100, C, C);
        add(0,1,0,1,0,5'b00_100, N, N);
        add(0,1,0,1,0,5'b00_100, N, C);
        add(0,1,0,1,0,5'b00_100, N, N);
        add(0,1,0,1,0,5'b00_100, N, N);
        // Descriptor changed at slot 3 of an 8-slot window
        add(1,1,0,1,1,5'b11_100, V, N);
        add(1,1,0,1,1,5'b11_100, V, N);
        add(1,1,0,1,1,5'b11_100, V, V);
        add(1,1,0,1,1,5'b00_001, V, V);
        add(1,1,0,1,1,5'b00_001, C, V);
        add(1,1,0,1,1,5'b00_001, C, V);
        add(1,1,0,1,1,5'b00_001, C, C);
        add(1,1,0,1,1,5'b00_001, C, C);
        add(1,1,0,1,1,5'b00_001, V, C);
        add(1,1,0,1,1,5'b00_001, C, C);
        add(1,1,0,1,1,5'b00_001, V, V);

        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_slot(tbl[i]);
            chk($sformatf("row%0d gnt", i),  gnt_now(),  {29'd0, oh(tbl[i].g)});
            chk($sformatf("row%0d bus", i),  bus_now(),  exp_bus(tbl[i]));
            chk($sformatf("row%0d strb", i), strb_now(), {29'd0, oh(tbl[i].s)});
            @(posedge clk);
            #1;
            chk($sformatf("row%0d gnt_end", i), gnt_now(), 32'd0);
            chk($sformatf("row%0d bus_hold", i), bus_now(), exp_bus(tbl[i]));
        end

        // Reset during a slot with a video return still in flight
        v.cr = 0; v.cw = 1; v.dr = 0; v.dw = 1; v.go = 1; v.bw = 5'b00_001;
        v.g = N; v.s = N;
        drive_slot(v);
        chk("pre-reset idle gnt", gnt_now(), 32'd0);
        drive_slot(v);
        chk("pre-reset vid gnt", gnt_now(), 32'b100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", all_out(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        v.cr = 1; v.bw = 5'b01_010;
        drive_slot(v);
        chk("post-reset slot0 gnt",  gnt_now(),  32'b100);
        chk("post-reset slot0 strb", strb_now(), 32'd0);
        drive_slot(v);
        chk("post-reset slot1 gnt",  gnt_now(),  32'b100);
        chk("post-reset slot1 strb", strb_now(), 32'd0);
        drive_slot(v);
        chk("post-reset slot2 gnt",  gnt_now(),  32'b010);
        chk("post-reset slot2 strb", strb_now(), 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
